// File: rtl/de_selector1n.sv
// 1:N demultiplexer with a one-word register per channel, addressed or round-robin routing.
// A word is accepted when its target channel is empty or draining that cycle, and it appears one clock later.
module de_selector1n #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  localparam int SW = $clog2(NCH)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [DW-1:0]     iC,
  input  logic              iValid,
  output logic              oReady,
  input  logic [SW-1:0]     iSel,
  input  logic              iMode,
  output logic [NCH*DW-1:0] oZ,
  output logic [NCH-1:0]    oValid,
  input  logic [NCH-1:0]    iReady,
  output logic [SW-1:0]     oPtr
);

  logic [NCH-1:0][DW-1:0] z_q;
  logic [NCH-1:0]         vld_q;
  logic [SW-1:0]          ptr_q;
  logic [SW-1:0]          tgt;
  logic                   accept;

  assign tgt    = iMode ? ptr_q : iSel;
  // A full target can still take a word in the same cycle its consumer drains it.
  assign oReady = ~vld_q[tgt] | iReady[tgt];
  assign accept = iValid & oReady;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      z_q   <= '0;
      vld_q <= '0;
      ptr_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (accept && (tgt == SW'(k))) begin
          z_q[k]   <= iC;
          vld_q[k] <= 1'b1;
        end else if (iReady[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
      if (accept && iMode) ptr_q <= ptr_q + SW'(1);
    end
  end

  assign oZ     = z_q;
  assign oValid = vld_q;
  assign oPtr   = ptr_q;

endmodule

// File: tb/tb_de_selector1n.sv
// Bench for de_selector1n: directed vector table, hand sequences, and random traffic against a mailbox model.
module tb_de_selector1n;
  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int SW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, valid, mode, ready;
  logic [DW-1:0]     c;
  logic [SW-1:0]     sel, ptr;
  logic [NCH-1:0]    iready, ovalid;
  logic [NCH*DW-1:0] z;

  de_selector1n #(.DW(DW), .NCH(NCH)) dut (
    .iClk(clk), .iRst(rst), .iC(c), .iValid(valid), .oReady(ready),
    .iSel(sel), .iMode(mode), .oZ(z), .oValid(ovalid), .iReady(iready), .oPtr(ptr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Each channel is a one-slot mailbox; the pointer is an integer modulo NCH.
  bit            m_full[NCH];
  logic [DW-1:0] m_data[NCH];
  int            m_ptr;
  bit            exp_ready;
  logic          obs_ready;

  function automatic int target();
    return mode ? m_ptr : int'(sel);
  endfunction

  function automatic bit model_ready();
    int t = target();
    return !m_full[t] || iready[t];
  endfunction

  task automatic model_clock();
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = '0;
      end
      m_ptr = 0;
    end else begin
      bit acc = valid && model_ready();
      int t   = target();
      for (int k = 0; k < NCH; k++)
        if (m_full[k] && iready[k]) m_full[k] = 1'b0;
      if (acc) begin
        m_full[t] = 1'b1;
        m_data[t] = c;
        if (mode) m_ptr = (m_ptr + 1) % NCH;
      end
    end
  endtask

  function automatic logic [NCH-1:0] m_valid();
    logic [NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic [NCH*DW-1:0] m_z();
    logic [NCH*DW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*DW +: DW] = m_data[k];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs must already be applied; samples oReady mid-cycle, then returns 1 time unit after the edge.
  task automatic step();
    @(negedge clk);
    exp_ready = model_ready();
    obs_ready = ready;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  typedef struct {
    logic           rst, valid, mode;
    logic [SW-1:0]  sel;
    logic [DW-1:0]  c;
    logic [NCH-1:0] rdy;
    logic           e_ready;
    logic [NCH-1:0] e_valid;
    logic [SW-1:0]  e_ptr;
    logic [NCH*DW-1:0] e_z;
  } vec_t;

  vec_t vt[14];

  logic [NCH-1:0]    snap_v;
  logic [NCH*DW-1:0] snap_z;
  logic [SW-1:0]     snap_p;

  initial begin
    //           rst   valid mode  sel   c      rdy      rdy? valid    ptr   z
    vt[0]  = '{1'b0, 1'b1, 1'b0, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 2'd0, 32'h00A5_0000};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 2'd2, 8'h77, 4'b0000, 1'b0, 4'b0100, 2'd0, 32'h00A5_0000};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 2'd2, 8'h5A, 4'b0100, 1'b1, 4'b0100, 2'd0, 32'h005A_0000};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'hEE, 4'b1111, 1'b1, 4'b0000, 2'd0, 32'h005A_0000};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 2'd3, 8'h01, 4'b1111, 1'b1, 4'b0001, 2'd1, 32'h005A_0001};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 2'd3, 8'h02, 4'b1111, 1'b1, 4'b0010, 2'd2, 32'h005A_0201};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 2'd3, 8'h03, 4'b1111, 1'b1, 4'b0100, 2'd3, 32'h0003_0201};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 2'd3, 8'h04, 4'b1111, 1'b1, 4'b1000, 2'd0, 32'h0403_0201};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 2'd3, 8'h05, 4'b1111, 1'b1, 4'b0001, 2'd1, 32'h0403_0205};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 2'd1, 8'h06, 4'b0000, 1'b1, 4'b0011, 2'd1, 32'h0403_0605};
    vt[10] = '{1'b0, 1'b1, 1'b1, 2'd0, 8'h07, 4'b0000, 1'b0, 4'b0011, 2'd1, 32'h0403_0605};
    vt[11] = '{1'b0, 1'b1, 1'b1, 2'd0, 8'h07, 4'b0000, 1'b0, 4'b0011, 2'd1, 32'h0403_0605};
    vt[12] = '{1'b0, 1'b1, 1'b1, 2'd0, 8'h07, 4'b0010, 1'b1, 4'b0011, 2'd2, 32'h0403_0705};
    vt[13] = '{1'b1, 1'b1, 1'b0, 2'd3, 8'hFF, 4'b0000, 1'b1, 4'b0000, 2'd0, 32'h0000_0000};

    rst = 1'b1; valid = 1'b0; mode = 1'b0; sel = '0; c = '0; iready = '0;
    m_ptr = 0;
    for (int k = 0; k < NCH; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
    end
    step();
    step();
    rst = 1'b0;
    check("reset_valid", 64'(ovalid), 64'(0));
    check("reset_z",     64'(z),      64'(0));
    check("reset_ptr",   64'(ptr),    64'(0));

    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; valid = vt[i].valid; mode = vt[i].mode;
      sel = vt[i].sel; c = vt[i].c; iready = vt[i].rdy;
      step();
      check($sformatf("vec%0d_ready", i), 64'(obs_ready), 64'(vt[i].e_ready));
      check($sformatf("vec%0d_valid", i), 64'(ovalid),    64'(vt[i].e_valid));
      check($sformatf("vec%0d_ptr", i),   64'(ptr),       64'(vt[i].e_ptr));
      check($sformatf("vec%0d_z", i),     64'(z),         64'(vt[i].e_z));
    end
    rst = 1'b0;

    // Fill every channel in addressed mode with 11..44.
    mode = 1'b0; iready = '0; valid = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      sel = SW'(k);
      c   = DW'((k + 1) * 8'h11);
      step();
    end
    valid = 1'b0;
    check("fill_valid", 64'(ovalid), 64'(4'b1111));
    check("fill_z",     64'(z),      64'(32'h4433_2211));

    // Idle traffic with garbage on the data/select lines must not disturb anything.
    snap_v = ovalid; snap_z = z; snap_p = ptr;
    for (int i = 0; i < 20; i++) begin
      c = DW'($urandom); sel = SW'($urandom); mode = 1'($urandom);
      step();
      check($sformatf("idle%0d_valid", i), 64'(ovalid), 64'(snap_v));
      check($sformatf("idle%0d_z", i),     64'(z),      64'(snap_z));
      check($sformatf("idle%0d_ptr", i),   64'(ptr),    64'(snap_p));
    end

    rst = 1'b1; mode = 1'b0;
    step();
    rst = 1'b0;
    check("midreset_valid", 64'(ovalid), 64'(0));
    check("midreset_z",     64'(z),      64'(0));
    check("midreset_ptr",   64'(ptr),    64'(0));

    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 39) == 0);
      valid  = 1'($urandom);
      mode   = ($urandom_range(0, 3) != 0);
      sel    = SW'($urandom);
      c      = DW'($urandom);
      iready = NCH'($urandom);
      step();
      check($sformatf("rnd%0d_ready", i), 64'(obs_ready), 64'(exp_ready));
      check($sformatf("rnd%0d_valid", i), 64'(ovalid),    64'(m_valid()));
      check($sformatf("rnd%0d_z", i),     64'(z),         64'(m_z()));
      check($sformatf("rnd%0d_ptr", i),   64'(ptr),       64'(m_ptr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/de_selector1n.md
DE_SELECTOR1N -- requirements
Module: de_selector1n

Interface
REQ-001 Parameter DW, default 8, data width of the input and of each output channel (1..32).
REQ-002 Parameter NCH, default 4, number of output channels; power of two, 2..16.
REQ-003 Derived constant SW = log2(NCH), width of the channel select and pointer.
REQ-004 iClk  input  1  single clock; all state updates on its rising edge.
REQ-005 iRst  input  1  reset, synchronous, active-high.
REQ-006 iC  input  DW  data to be routed.
REQ-007 iValid  input  1  iC holds a valid word this cycle.
REQ-008 oReady  output  1  the target channel can accept iC this cycle.
REQ-009 iSel  input  SW  channel select in addressed mode.
REQ-010 iMode  input  1  0 = addressed (iSel), 1 = auto round-robin (internal pointer).
REQ-011 oZ  output  NCH*DW  channel data, flattened; channel k in bits [k*DW +: DW].
REQ-012 oValid  output  NCH  bit k set = channel k holds an unconsumed word.
REQ-013 iReady  input  NCH  bit k set = consumer k takes its word this cycle.
REQ-014 oPtr  output  SW  current round-robin pointer.

Function
REQ-015 Target channel t SHALL be iSel when iMode=0 and oPtr when iMode=1, evaluated combinationally in the same cycle.
REQ-016 oReady SHALL equal ~oValid[t] | iReady[t] (combinational; no dependence on iValid).
REQ-017 Transfer "accept" SHALL occur in a cycle where iValid=1 and oReady=1.
REQ-018 On accept, oZ channel t SHALL load iC and oValid[t] SHALL be 1 on the next cycle (latency 1 clock).
REQ-019 A channel k with oValid[k]=1, iReady[k]=1 and not loaded in the same cycle SHALL clear oValid[k] next cycle; its oZ field holds its last value.
REQ-020 Simultaneous drain and load on the same channel SHALL leave oValid[t]=1 with the new word; no word lost, no bubble.
REQ-021 While oValid[k]=1 and iReady[k]=0, oZ channel k SHALL remain unchanged.
REQ-022 Channels other than t SHALL never be written by iC, regardless of iValid.
REQ-023 When iValid=1 and oReady=0, no state SHALL change for channel t and oPtr SHALL not advance; iC must be held by the source.
REQ-024 In iMode=1, oPtr SHALL increment by 1 on each accept, wrapping from NCH-1 to 0.
REQ-025 In iMode=0, oPtr SHALL hold its value; a mode change takes effect in the same cycle and does not alter oPtr.
REQ-026 iReady[k] with oValid[k]=0 SHALL have no effect.
REQ-027 Each channel drains independently; up to NCH channels may hold words concurrently.

Reset
REQ-028 With iRst=1 at a rising edge, oValid SHALL become all 0, oZ all 0, oPtr 0, on the next cycle.
REQ-029 Reset SHALL dominate any accept or drain in the same cycle; a word presented then is discarded.
REQ-030 During iRst=1 oReady SHALL follow REQ-016 on post-reset-cleared state only after the clock edge; no accept is recorded while iRst=1.

Verification
REQ-031 Reset mid-operation: fill channels 0..3 with 8'h11..8'h44, assert iRst one cycle -> oValid=4'b0000, oZ=0, oPtr=0 next cycle.
REQ-032 Addressed mode: iMode=0, iSel=2, iC=8'hA5, iValid=1, iReady=0 -> next cycle oValid=4'b0100, oZ[23:16]=8'hA5; second word to iSel=2 sees oReady=0, oZ unchanged.
REQ-033 Drain+load same cycle: channel 2 full with 8'hA5, iReady[2]=1, iC=8'h5A to iSel=2 -> oReady=1, next cycle oValid[2]=1, oZ[23:16]=8'h5A.
REQ-034 Round-robin wrap: iMode=1, iReady=4'b1111, five accepts 8'h01..8'h05 -> words land on channels 0,1,2,3,0; oPtr sequence 0,1,2,3,0,1.
REQ-035 Back-pressure in auto mode: iMode=1, oPtr=1, oValid[1]=1, iReady[1]=0, iValid=1 -> oReady=0, oPtr stays 1 until iReady[1]=1, then accept and oPtr=2.
REQ-036 Isolation: iValid=0 with random iC/iSel for 20 cycles -> oValid and oZ unchanged throughout.
